// File: rtl/tarot_card_picker_pkg.sv
// Shared constants, state encoding and index helpers for the tarot card picker.
package tarot_pkg;

    localparam int DECK_SIZE  = 78;
    localparam int CARD_W     = 7;
    localparam int DECK_SCALE = 78;
    localparam int SAMPLE_W   = 16;
    localparam int PROD_W     = SAMPLE_W + CARD_W;

    localparam logic [CARD_W-1:0] FIRST_CARD = 7'd0;
    localparam logic [CARD_W-1:0] LAST_CARD  = 7'd77;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        PROBE = 3'd4,
        EMIT  = 3'd5,
        DONE  = 3'd6
    } picker_state_e;

    // Multiply-high scaling keeps the result in 0..DECK_SIZE-1 without a divider.
    function automatic logic [CARD_W-1:0] scale_index(input logic [SAMPLE_W-1:0] sample);
        logic [PROD_W-1:0] product;
        product = PROD_W'(sample) * PROD_W'(DECK_SCALE);
        return product[PROD_W-1:SAMPLE_W];
    endfunction

    function automatic logic [CARD_W-1:0] next_card(input logic [CARD_W-1:0] idx);
        logic [CARD_W-1:0] nxt;
        if (idx == LAST_CARD) begin
            nxt = FIRST_CARD;
        end else begin
            nxt = idx + 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tarot_card_picker_index_scale.sv
// Combinational 16-bit sample to card index mapping (0..77).
module tarot_index_scale
    import tarot_pkg::*;
(
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [CARD_W-1:0]   idx_o
);

    assign idx_o = scale_index(sample_i);

endmodule

// File: rtl/tarot_card_picker.sv
// Draws NUM_CARDS distinct tarot cards from PRNG samples, with a linear-probe fallback.
// Optional build macro TAROT_REVERSAL_EN enables card orientation from rand_y[31].
module tarot_card_picker
    import tarot_pkg::*;
#(
    parameter int NUM_CARDS   = 3,
    parameter int MAX_RETRIES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [31:0]                  rand_x,
    input  logic [31:0]                  rand_y,
    input  logic                         rand_valid,
    output logic                         rand_req,
    output logic [CARD_W-1:0]            card_idx,
    output logic                         card_reversed,
    output logic                         card_valid,
    output logic [$clog2(NUM_CARDS):0]   card_num,
    output logic                         draw_done
);

    localparam int CNT_W = $clog2(NUM_CARDS) + 1;
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] CARDS_TOTAL = CNT_W'(NUM_CARDS);
    localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRIES);

    picker_state_e         state_q;
    logic [DECK_SIZE-1:0]  used_q;
    logic [RTY_W-1:0]      retry_q;
    logic [CNT_W-1:0]      count_q;
    logic                  rand_valid_q;
    logic [CARD_W-1:0]     idx_q;
    logic                  rev_q;

    logic                  rand_req_q;
    logic [CARD_W-1:0]     card_idx_q;
    logic                  card_rev_q;
    logic                  card_valid_q;
    logic [CNT_W-1:0]      card_num_q;
    logic                  draw_done_q;

    logic [CARD_W-1:0]     scaled_idx_s;
    logic [CARD_W-1:0]     probe_idx_s;
    logic [CARD_W-1:0]     accept_idx_s;
    logic                  accept_s;
    logic                  rv_edge_s;
    logic                  retry_full_s;
    logic                  rev_bit_s;
    logic                  unused_inputs_s;

    tarot_index_scale u_scale (
        .sample_i (rand_x[SAMPLE_W-1:0]),
        .idx_o    (scaled_idx_s)
    );

`ifdef TAROT_REVERSAL_EN
    assign rev_bit_s       = rand_y[31];
    assign unused_inputs_s = ^{rand_x[31:SAMPLE_W], rand_y[30:0]};
`else
    assign rev_bit_s       = 1'b0;
    assign unused_inputs_s = ^{rand_x[31:SAMPLE_W], rand_y};
`endif

    assign rv_edge_s    = rand_valid & ~rand_valid_q;
    assign retry_full_s = ((retry_q + RTY_W'(1)) == RETRY_LIMIT);

    // Acceptance test: CHECK looks at the sampled index, PROBE at the next one in the ring.
    always_comb begin
        probe_idx_s  = next_card(idx_q);
        accept_s     = 1'b0;
        accept_idx_s = idx_q;
        case (state_q)
            CHECK: begin
                accept_s     = ~used_q[idx_q];
                accept_idx_s = idx_q;
            end
            PROBE: begin
                accept_s     = ~used_q[probe_idx_s];
                accept_idx_s = probe_idx_s;
            end
            default: begin
                accept_s     = 1'b0;
                accept_idx_s = idx_q;
            end
        endcase
    end

    // Picker FSM; every output is registered and describes the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            used_q       <= '0;
            retry_q      <= '0;
            count_q      <= '0;
            rand_valid_q <= 1'b0;
            idx_q        <= '0;
            rev_q        <= 1'b0;
            rand_req_q   <= 1'b0;
            card_idx_q   <= '0;
            card_rev_q   <= 1'b0;
            card_valid_q <= 1'b0;
            card_num_q   <= '0;
            draw_done_q  <= 1'b0;
        end else begin
            rand_valid_q <= rand_valid;
            rand_req_q   <= 1'b0;
            card_valid_q <= 1'b0;

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        used_q      <= '0;
                        retry_q     <= '0;
                        count_q     <= '0;
                        draw_done_q <= 1'b0;
                        rand_req_q  <= 1'b1;
                        state_q     <= REQ;
                    end else begin
                        state_q     <= state_q;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (rv_edge_s) begin
                        idx_q   <= scaled_idx_s;
                        rev_q   <= rev_bit_s;
                        state_q <= CHECK;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                CHECK: begin
                    if (accept_s) begin
                        state_q    <= EMIT;
                    end else if (retry_full_s) begin
                        retry_q    <= retry_q + RTY_W'(1);
                        state_q    <= PROBE;
                    end else begin
                        retry_q    <= retry_q + RTY_W'(1);
                        rand_req_q <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                PROBE: begin
                    idx_q <= probe_idx_s;
                    if (accept_s) begin
                        state_q <= EMIT;
                    end else begin
                        state_q <= PROBE;
                    end
                end
                EMIT: begin
                    if (count_q == CARDS_TOTAL) begin
                        draw_done_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rand_req_q  <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Commit an accepted card; the count is already advanced when EMIT is entered.
            if (accept_s) begin
                used_q[accept_idx_s] <= 1'b1;
                retry_q              <= '0;
                card_idx_q           <= accept_idx_s;
                card_rev_q           <= rev_q;
                card_valid_q         <= 1'b1;
                card_num_q           <= count_q;
                count_q              <= count_q + CNT_W'(1);
            end else begin
                card_valid_q         <= 1'b0;
            end
        end
    end

    assign rand_req      = rand_req_q;
    assign card_idx      = card_idx_q;
    assign card_reversed = card_rev_q;
    assign card_valid    = card_valid_q;
    assign card_num      = card_num_q;
    assign draw_done     = draw_done_q;

endmodule
